nibble_search_ctrl: RTL and testbench



---
 rtl/nibble_search_ctrl.sv | 171 +++++++++++++++++
 tb/tb_nibble_search_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_search_ctrl.sv
// Scan sequencer for a DEPTH-entry nibble table using one shared W-bit equality comparator.
// Optional macro NIBBLE_SEARCH_COUNT_EN: full-table scan with a match counter instead of first-match exit.

module nibble_eq #(
   parameter int W = 4
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic         eq_o
);
   logic [W-1:0] bit_eq;

   assign bit_eq = ~(a_i ^ b_i);
   assign eq_o   = &bit_eq;
endmodule

// state | meaning
// IDLE  | waiting for start; result outputs hold the last search
// SCAN  | comparing table[ptr] against the latched key, one entry per clock
// DONE  | one-cycle completion pulse, then back to IDLE
module nibble_search_ctrl #(
   parameter int W     = 4,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data,
   input  logic          start,
   input  logic [W-1:0]  key,
   output logic          busy,
   output logic          done,
   output logic          found,
   output logic [AW-1:0] index,
   output logic [AW:0]   match_cnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  table_q [DEPTH];
   logic [W-1:0]  key_q, key_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic          found_q, found_d;
   logic [AW-1:0] index_q, index_d;
   logic          hit;
   logic          last;

   assign last = (ptr_q == AW'(DEPTH - 1));

   // The only equality logic in the block; everything else keys off hit.
   nibble_eq #(.W(W)) u_eq (
      .a_i  (key_q),
      .b_i  (table_q[ptr_q]),
      .eq_o (hit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            table_q[i] <= '0;
         end
      end else if (wr_en) begin
         table_q[wr_addr] <= wr_data;
      end
   end

`ifdef NIBBLE_SEARCH_COUNT_EN
   logic [AW:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign match_cnt = cnt_q;
`else
   assign match_cnt = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         key_q   <= '0;
         ptr_q   <= '0;
         found_q <= 1'b0;
         index_q <= '0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         ptr_q   <= ptr_d;
         found_q <= found_d;
         index_q <= index_d;
      end
   end

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      ptr_d   = ptr_q;
      found_d = found_q;
      index_d = index_q;
`ifdef NIBBLE_SEARCH_COUNT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               key_d   = key;
               ptr_d   = '0;
               found_d = 1'b0;
               index_d = '0;
`ifdef NIBBLE_SEARCH_COUNT_EN
               cnt_d   = '0;
`endif
               state_d = S_SCAN;
            end
         end
         S_SCAN: begin
`ifdef NIBBLE_SEARCH_COUNT_EN
            // Full sweep; index keeps the first hit because found_q is still low then.
            if (hit) begin
               cnt_d   = cnt_q + (AW + 1)'(1);
               found_d = 1'b1;
               if (!found_q) begin
                  index_d = ptr_q;
               end
            end
            if (last) begin
               state_d = S_DONE;
            end else begin
               ptr_d = ptr_q + AW'(1);
            end
`else
            if (hit) begin
               found_d = 1'b1;
               index_d = ptr_q;
               state_d = S_DONE;
            end else if (last) begin
               found_d = 1'b0;
               index_d = '0;
               state_d = S_DONE;
            end else begin
               ptr_d = ptr_q + AW'(1);
            end
`endif
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy  = (state_q == S_SCAN);
   assign done  = (state_q == S_DONE);
   assign found = found_q;
   assign index = index_q;

endmodule

// File: tb/tb_nibble_search_ctrl.sv
// Directed bench for nibble_search_ctrl; expectations adapt to NIBBLE_SEARCH_COUNT_EN.

module tb_nibble_search_ctrl;

`ifdef NIBBLE_SEARCH_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_en = 1'b0;
   logic [2:0] wr_addr = '0;
   logic [3:0] wr_data = '0;
   logic       start = 1'b0;
   logic [3:0] key = '0;
   logic       busy;
   logic       done;
   logic       found;
   logic [2:0] index;
   logic [3:0] match_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   nibble_search_ctrl #(.W(4), .DEPTH(8), .AW(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .start     (start),
      .key       (key),
      .busy      (busy),
      .done      (done),
      .found     (found),
      .index     (index),
      .match_cnt (match_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_entry(input logic [2:0] a, input logic [3:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      tick();
      wr_en   = 1'b0;
   endtask

   // Advance until done or a cycle budget expires; k counts edges since the start edge.
   task automatic wait_done(inout int k, inout int bsy);
      while (done !== 1'b1 && k < 40) begin
         if (busy === 1'b1) bsy++;
         tick();
         k++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      n_checks++;
      if ({busy, done, found, index, match_cnt} !== 9'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%b done=%b found=%b index=%0d cnt=%0d, want all 0",
                  busy, done, found, index, match_cnt);
      end
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
      end
   endtask

   task automatic test_search(input string name, input logic [3:0] k_in, input logic exp_found,
                              input logic [2:0] exp_idx, input int exp_lat, input logic [3:0] exp_cnt);
      int k = 0;
      int bsy = 0;
      key   = k_in;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(k, bsy);
      n_checks++;
      if (k !== exp_lat) begin
         n_fail++;
         $display("FAIL %s_latency: got %0d, want %0d", name, k, exp_lat);
      end
      n_checks++;
      if (bsy !== exp_lat) begin
         n_fail++;
         $display("FAIL %s_busy_cycles: got %0d, want %0d", name, bsy, exp_lat);
      end
      n_checks++;
      if (found !== exp_found || index !== exp_idx || match_cnt !== exp_cnt || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_result: got found=%b index=%0d cnt=%0d busy=%b, want %b %0d %0d 0",
                  name, found, index, match_cnt, busy, exp_found, exp_idx, exp_cnt);
      end
      tick();
      n_checks++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_done_width: got done=%b one cycle later, want 0", name, done);
      end
   endtask

   task automatic test_hold();
      for (int i = 0; i < 3; i++) tick();
      n_checks++;
      if (found !== 1'b0 || index !== 3'd0 || done !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_miss: got found=%b index=%0d done=%b busy=%b, want 0 0 0 0",
                  found, index, done, busy);
      end
   endtask

   task automatic test_write_during_scan(input string name, input logic [2:0] a,
                                         input logic exp_found, input logic [2:0] exp_idx);
      int k = 0;
      int bsy = 0;
      key   = 4'h9;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (busy === 1'b1) bsy++;
         tick();
         k++;
      end
      // Now in the cycle where entry 3 is compared.
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = 4'h9;
      if (busy === 1'b1) bsy++;
      tick();
      k++;
      wr_en = 1'b0;
      wait_done(k, bsy);
      n_checks++;
      if (k !== 8) begin
         n_fail++;
         $display("FAIL %s_latency: got %0d, want 8", name, k);
      end
      n_checks++;
      if (found !== exp_found || index !== exp_idx || match_cnt !== (CNT_EN ? {3'b0, exp_found} : 4'd0)) begin
         n_fail++;
         $display("FAIL %s_result: got found=%b index=%0d cnt=%0d, want %b %0d", name, found, index,
                  match_cnt, exp_found, exp_idx);
      end
      tick();
   endtask

   task automatic test_start_ignored();
      int k = 0;
      int bsy = 0;
      int pulses = 0;
      key   = 4'h5;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         k++;
      end
      // ptr is 2: a re-start with key 3 would hit entry 3 if it were taken.
      start = 1'b1;
      key   = 4'h3;
      tick();
      k++;
      start = 1'b0;
      wait_done(k, bsy);
      n_checks++;
      if (k !== (CNT_EN ? 8 : 6)) begin
         n_fail++;
         $display("FAIL restart_latency: got %0d, want %0d", k, CNT_EN ? 8 : 6);
      end
      n_checks++;
      if (found !== 1'b1 || index !== 3'd5) begin
         n_fail++;
         $display("FAIL restart_result: got found=%b index=%0d, want 1 5", found, index);
      end
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done === 1'b1) pulses++;
      end
      n_checks++;
      if (pulses !== 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL restart_extra_done: got %0d extra pulses busy=%b, want 0 0", pulses, busy);
      end
   endtask

   task automatic test_reset_mid_scan();
      int pulses = 0;
      key   = 4'h7;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_pre_busy: got %b, want 1", busy);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, done, found, index, match_cnt} !== 9'b0) begin
         n_fail++;
         $display("FAIL midrst_outputs: got busy=%b done=%b found=%b index=%0d cnt=%0d, want all 0",
                  busy, done, found, index, match_cnt);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         if (done === 1'b1) pulses++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (done === 1'b1) pulses++;
      end
      n_checks++;
      if (pulses !== 0) begin
         n_fail++;
         $display("FAIL midrst_done: got %0d done pulses, want 0", pulses);
      end
      test_search("cleared", 4'h0, 1'b1, 3'd0, CNT_EN ? 8 : 1, CNT_EN ? 4'd8 : 4'd0);
   endtask

   initial begin
      test_reset();
      for (int i = 0; i < 8; i++) wr_entry(3'(i), 4'(i));
      test_search("hit4", 4'h4, 1'b1, 3'd4, CNT_EN ? 8 : 5, CNT_EN ? 4'd1 : 4'd0);
      test_search("miss", 4'hF, 1'b0, 3'd0, 8, 4'd0);
      test_hold();
      wr_entry(3'd2, 4'hA);
      wr_entry(3'd6, 4'hA);
      test_search("dupA", 4'hA, 1'b1, 3'd2, CNT_EN ? 8 : 3, CNT_EN ? 4'd2 : 4'd0);
      wr_entry(3'd2, 4'h2);
      wr_entry(3'd6, 4'h6);
      test_write_during_scan("wr_ahead", 3'd7, 1'b1, 3'd7);
      wr_entry(3'd7, 4'h7);
      test_write_during_scan("wr_behind", 3'd1, 1'b0, 3'd0);
      wr_entry(3'd1, 4'h1);
      test_start_ignored();
      test_reset_mid_scan();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
